// File: rtl/branch_pkg.sv
// Shared constants for the branch resolve queue: fall-through stride and
// the bit layout of one queued entry {pc, target, prediction}.
package branch_pkg;

    localparam int BR_FALLTHROUGH = 4;

    // Entry layout, LSB first: prediction, target[ADDR_W], pc[ADDR_W]
    localparam int BR_PRED_OFF = 0;
    localparam int BR_TGT_OFF  = 1;

    function automatic int br_pc_off(input int addr_w);
        return addr_w + 1;
    endfunction

    function automatic int br_entry_w(input int addr_w);
        return 2 * addr_w + 1;
    endfunction

endpackage

// File: rtl/branch_resolve_fifo.sv
// Circular buffer of in-flight branch entries with push, pop and a
// whole-queue clear that wins over both in the same cycle.
module branch_resolve_fifo
    import branch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    input  logic             clear_i,
    output logic [WIDTH-1:0] head_data_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_fire;
    logic             pop_fire;

    assign empty_o     = (count_q == '0);
    assign full_o      = (count_q == CNT_W'(DEPTH));
    assign head_data_o = mem_q[head_q];

    always_comb begin
        push_fire = push_i && !full_o && !clear_i;
        pop_fire  = pop_i && !empty_o && !clear_i;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (clear_i) begin
            // Everything still queued is younger than the mispredicted branch
            head_d  = tail_q;
            count_d = '0;
        end else begin
            if (pop_fire)  head_d = head_q + PTR_W'(1);
            if (push_fire) tail_d = tail_q + PTR_W'(1);
            case ({push_fire, pop_fire})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_fire) mem_q[tail_q] <= push_data_i;
    end

endmodule

// File: rtl/branch_resolve_queue.sv
// Tracks in-flight branch predictions and emits predictor updates and
// mispredict redirects on resolve. Optional counters: BRANCH_STATS_EN.
module branch_resolve_queue
    import branch_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_valid,
    input  logic [ADDR_W-1:0] push_pc,
    input  logic              push_prediction,
    input  logic [ADDR_W-1:0] push_target,
    output logic              push_ready,
    input  logic              resolve_valid,
    input  logic              resolve_taken,
    input  logic [ADDR_W-1:0] resolve_target,
    output logic              update_valid,
    output logic [ADDR_W-1:0] update_branch_addr,
    output logic              update_decision,
    output logic              mispredict,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              underflow_err,
    output logic [31:0]       stat_branches,
    output logic [31:0]       stat_mispredicts
);

    localparam int ENTRY_W = br_entry_w(ADDR_W);
    localparam int PC_OFF  = br_pc_off(ADDR_W);

    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;
    logic               q_empty;
    logic               q_full;
    logic [ADDR_W-1:0]  head_pc;
    logic [ADDR_W-1:0]  head_target;
    logic               head_pred;
    logic               resolve_fire;
    logic               mispredict_c;
    logic [ADDR_W-1:0]  redirect_c;

    logic              update_valid_q,    update_valid_d;
    logic [ADDR_W-1:0] update_addr_q,     update_addr_d;
    logic              update_decision_q, update_decision_d;
    logic              mispredict_q,      mispredict_d;
    logic [ADDR_W-1:0] redirect_pc_q,     redirect_pc_d;
    logic              underflow_q,       underflow_d;

    assign push_entry = {push_pc, push_target, push_prediction};
    assign push_ready = !q_full;

    branch_resolve_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_valid),
        .push_data_i (push_entry),
        .pop_i       (resolve_fire),
        .clear_i     (resolve_fire && mispredict_c),
        .head_data_o (head_entry),
        .empty_o     (q_empty),
        .full_o      (q_full)
    );

    assign head_pc     = head_entry[PC_OFF +: ADDR_W];
    assign head_target = head_entry[BR_TGT_OFF +: ADDR_W];
    assign head_pred   = head_entry[BR_PRED_OFF];

    always_comb begin
        resolve_fire = resolve_valid && !q_empty;
        mispredict_c = (head_pred != resolve_taken) ||
                       (resolve_taken && (head_target != resolve_target));
        redirect_c   = resolve_taken ? resolve_target
                                     : head_pc + ADDR_W'(BR_FALLTHROUGH);
    end

    always_comb begin
        update_valid_d    = resolve_fire;
        update_addr_d     = update_addr_q;
        update_decision_d = update_decision_q;
        mispredict_d      = resolve_fire && mispredict_c;
        redirect_pc_d     = redirect_pc_q;
        underflow_d       = underflow_q || (resolve_valid && q_empty);
        if (resolve_fire) begin
            update_addr_d     = head_pc;
            update_decision_d = resolve_taken;
            redirect_pc_d     = redirect_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            update_valid_q    <= 1'b0;
            update_addr_q     <= '0;
            update_decision_q <= 1'b0;
            mispredict_q      <= 1'b0;
            redirect_pc_q     <= '0;
            underflow_q       <= 1'b0;
        end else begin
            update_valid_q    <= update_valid_d;
            update_addr_q     <= update_addr_d;
            update_decision_q <= update_decision_d;
            mispredict_q      <= mispredict_d;
            redirect_pc_q     <= redirect_pc_d;
            underflow_q       <= underflow_d;
        end
    end

    assign update_valid       = update_valid_q;
    assign update_branch_addr = update_addr_q;
    assign update_decision    = update_decision_q;
    assign mispredict         = mispredict_q;
    assign redirect_pc        = redirect_pc_q;
    assign underflow_err      = underflow_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_br_q, stat_br_d;
    logic [31:0] stat_mp_q, stat_mp_d;

    // Saturating so a long run never wraps back to a small count
    always_comb begin
        stat_br_d = stat_br_q;
        stat_mp_d = stat_mp_q;
        if (resolve_fire && (stat_br_q != 32'hFFFF_FFFF))
            stat_br_d = stat_br_q + 32'd1;
        if (resolve_fire && mispredict_c && (stat_mp_q != 32'hFFFF_FFFF))
            stat_mp_d = stat_mp_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            stat_br_q <= stat_br_d;
            stat_mp_q <= stat_mp_d;
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;
`else
    assign stat_branches    = 32'd0;
    assign stat_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue; stat checks follow BRANCH_STATS_EN.
module tb_branch_resolve_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        push_valid;
    logic [31:0] push_pc;
    logic        push_prediction;
    logic [31:0] push_target;
    logic        push_ready;
    logic        resolve_valid;
    logic        resolve_taken;
    logic [31:0] resolve_target;
    logic        update_valid;
    logic [31:0] update_branch_addr;
    logic        update_decision;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic        underflow_err;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_resolve_queue #(.DEPTH(4), .ADDR_W(32)) dut (
        .clk                (clk),
        .rst                (rst),
        .push_valid         (push_valid),
        .push_pc            (push_pc),
        .push_prediction    (push_prediction),
        .push_target        (push_target),
        .push_ready         (push_ready),
        .resolve_valid      (resolve_valid),
        .resolve_taken      (resolve_taken),
        .resolve_target     (resolve_target),
        .update_valid       (update_valid),
        .update_branch_addr (update_branch_addr),
        .update_decision    (update_decision),
        .mispredict         (mispredict),
        .redirect_pc        (redirect_pc),
        .underflow_err      (underflow_err),
        .stat_branches      (stat_branches),
        .stat_mispredicts   (stat_mispredicts)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_push(input logic v, input logic [31:0] pc, input logic pred, input logic [31:0] tgt);
        push_valid = v; push_pc = pc; push_prediction = pred; push_target = tgt;
    endtask

    task automatic set_res(input logic v, input logic taken, input logic [31:0] tgt);
        resolve_valid = v; resolve_taken = taken; resolve_target = tgt;
    endtask

    task automatic idle();
        set_push(1'b0, 32'h0, 1'b0, 32'h0);
        set_res(1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("reset push_ready", {31'd0, push_ready}, 32'd1);
        chk("reset update_valid", {31'd0, update_valid}, 32'd0);
        chk("reset mispredict", {31'd0, mispredict}, 32'd0);
        chk("reset redirect_pc", redirect_pc, 32'h0);
        chk("reset underflow", {31'd0, underflow_err}, 32'd0);
        chk("reset stat_br", stat_branches, 32'd0);

        // 1: correct taken prediction
        set_push(1'b1, 32'h10, 1'b1, 32'h40); tick();
        idle(); set_res(1'b1, 1'b1, 32'h40); tick();
        idle();
        $display("t1 resolve pc=0x10 taken tgt=0x40");
        chk("t1 update_valid", {31'd0, update_valid}, 32'd1);
        chk("t1 update_addr", update_branch_addr, 32'h10);
        chk("t1 decision", {31'd0, update_decision}, 32'd1);
        chk("t1 mispredict", {31'd0, mispredict}, 32'd0);
        tick();
        chk("t1 update pulse", {31'd0, update_valid}, 32'd0);

        // 2: predicted not-taken, actually taken
        set_push(1'b1, 32'h20, 1'b0, 32'h0); tick();
        idle(); set_res(1'b1, 1'b1, 32'h80); tick();
        idle();
        $display("t2 resolve pc=0x20 pred=0 taken tgt=0x80");
        chk("t2 mispredict", {31'd0, mispredict}, 32'd1);
        chk("t2 redirect", redirect_pc, 32'h80);
        chk("t2 decision", {31'd0, update_decision}, 32'd1);
        chk("t2 update_addr", update_branch_addr, 32'h20);
        tick();
        chk("t2 mispredict pulse", {31'd0, mispredict}, 32'd0);

        // 3: predicted taken, actually not-taken -> fall through
        set_push(1'b1, 32'h30, 1'b1, 32'h90); tick();
        idle(); set_res(1'b1, 1'b0, 32'h0); tick();
        idle();
        $display("t3 resolve pc=0x30 pred=1 not-taken");
        chk("t3 mispredict", {31'd0, mispredict}, 32'd1);
        chk("t3 redirect", redirect_pc, 32'h34);
        chk("t3 decision", {31'd0, update_decision}, 32'd0);
`ifdef BRANCH_STATS_EN
        chk("t3 stat_br", stat_branches, 32'd3);
        chk("t3 stat_mp", stat_mispredicts, 32'd2);
`else
        chk("t3 stat_br tied", stat_branches, 32'd0);
        chk("t3 stat_mp tied", stat_mispredicts, 32'd0);
`endif

        // 4: fill to DEPTH, fifth push dropped, drain in order
        for (int i = 0; i < 4; i++) begin
            set_push(1'b1, 32'h100 + 32'(4 * i), 1'b0, 32'h0); tick();
        end
        idle();
        chk("t4 full push_ready", {31'd0, push_ready}, 32'd0);
        set_push(1'b1, 32'h200, 1'b0, 32'h0); tick();
        idle();
        for (int i = 0; i < 4; i++) begin
            set_res(1'b1, 1'b0, 32'h0); tick();
            idle();
            $display("t4 resolve %0d addr=0x%08h", i, update_branch_addr);
            chk("t4 update_valid", {31'd0, update_valid}, 32'd1);
            chk("t4 update_addr", update_branch_addr, 32'h100 + 32'(4 * i));
            chk("t4 no mispredict", {31'd0, mispredict}, 32'd0);
        end
        chk("t4 drained push_ready", {31'd0, push_ready}, 32'd1);

        // Simultaneous push + correct resolve keeps both
        set_push(1'b1, 32'h700, 1'b0, 32'h0); tick();
        set_push(1'b1, 32'h704, 1'b1, 32'h720); set_res(1'b1, 1'b0, 32'h0); tick();
        idle();
        chk("tpr update_addr A", update_branch_addr, 32'h700);
        set_res(1'b1, 1'b1, 32'h720); tick();
        idle();
        $display("tpr resolve B addr=0x%08h", update_branch_addr);
        chk("tpr update_valid B", {31'd0, update_valid}, 32'd1);
        chk("tpr update_addr B", update_branch_addr, 32'h704);
        chk("tpr no mispredict", {31'd0, mispredict}, 32'd0);

        // 5: mispredict flushes queue and squashes a concurrent push
        for (int i = 0; i < 3; i++) begin
            set_push(1'b1, 32'h300 + 32'(4 * i), 1'b1, 32'h500); tick();
        end
        set_push(1'b1, 32'h400, 1'b1, 32'h500); set_res(1'b1, 1'b1, 32'h600); tick();
        idle();
        $display("t5 flush resolve redirect=0x%08h", redirect_pc);
        chk("t5 mispredict", {31'd0, mispredict}, 32'd1);
        chk("t5 redirect", redirect_pc, 32'h600);
        chk("t5 push_ready", {31'd0, push_ready}, 32'd1);
        set_res(1'b1, 1'b1, 32'h500); tick();
        idle();
        chk("t5 no update when empty", {31'd0, update_valid}, 32'd0);
        chk("t5 underflow", {31'd0, underflow_err}, 32'd1);
        tick();
        chk("t5 underflow sticky", {31'd0, underflow_err}, 32'd1);

        // 6: reset mid-queue discards entries and clears stats
        set_push(1'b1, 32'h800, 1'b0, 32'h0); tick();
        set_push(1'b1, 32'h804, 1'b0, 32'h0); tick();
        idle();
        rst = 1'b1; tick();
        rst = 1'b0; tick();
        chk("t6 underflow cleared", {31'd0, underflow_err}, 32'd0);
        chk("t6 stat_br", stat_branches, 32'd0);
        chk("t6 stat_mp", stat_mispredicts, 32'd0);
        set_res(1'b1, 1'b0, 32'h0); tick();
        idle();
        $display("t6 resolve after reset update_valid=%0d", update_valid);
        chk("t6 no update", {31'd0, update_valid}, 32'd0);
        chk("t6 underflow", {31'd0, underflow_err}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
